// File: rtl/mux_32bits_if.sv
// Bus bundle for the 2:1 datapath word selector: operands, select and
// hold in; combinational word plus registered copy and flags out.
interface mux_32bits_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in_0;
    logic [WIDTH-1:0] in_1;
    logic             select_line;
    logic             hold;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_q;
    logic             out_valid;
    logic             sel_changed;

    modport master (
        output in_0, in_1, select_line, hold,
        input  out, out_q, out_valid, sel_changed
    );

    modport slave (
        input  in_0, in_1, select_line, hold,
        output out, out_q, out_valid, sel_changed
    );
endinterface

// File: rtl/mux_32bits.sv
// 2:1 word selector for the MIPS datapath: zero-latency combinational output
// plus a holdable registered copy with valid and select-change flags.
module mux_32bits #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    mux_32bits_if.slave  bus
);
    logic sel_q;

    // Conditional operator keeps an unknown select visible as X in simulation.
    assign bus.out = bus.select_line ? bus.in_1 : bus.in_0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_q       <= RESET_VALUE;
            bus.out_valid   <= 1'b0;
            bus.sel_changed <= 1'b0;
            sel_q           <= 1'b0;
        end else if (!bus.hold) begin
            bus.out_q       <= bus.out;
            bus.out_valid   <= 1'b1;
            bus.sel_changed <= (bus.select_line != sel_q);
            sel_q           <= bus.select_line;
        end else begin
            // Held cycles freeze the data path but never report a select change.
            bus.sel_changed <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mux_32bits.sv
// Directed vector bench for mux_32bits: per-cycle table of inputs with
// hand-computed combinational and registered expectations.
module tb_mux_32bits;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    mux_32bits_if #(.WIDTH(32)) bus ();

    mux_32bits #(.WIDTH(32), .RESET_VALUE(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        hold;
        logic        sel;
        logic [31:0] in_0;
        logic [31:0] in_1;
        logic [31:0] exp_out;
        logic [31:0] exp_q;
        logic        exp_valid;
        logic        exp_chg;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        //           rst hold sel in_0          in_1          out           out_q        vld chg
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h01234567, 32'h89ABCDEF, 32'h01234567, 32'h01234567, 1'b1, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'h01234567, 32'h89ABCDEF, 32'h89ABCDEF, 32'h89ABCDEF, 1'b1, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'h01234567, 32'h89ABCDEF, 32'h89ABCDEF, 32'h89ABCDEF, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'hA0B9C153, 32'hAAAAAAAA, 32'hA0B9C153, 32'hA0B9C153, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'hA0B9C153, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'hD0B7BC27, 32'h0B61AF23, 32'hD0B7BC27, 32'hD0B7BC27, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'hD0B7BC27, 32'h0B61AF23, 32'h0B61AF23, 32'h0B61AF23, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h2F4843D8, 32'hF49E50DC, 32'h2F4843D8, 32'h2F4843D8, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 32'h2F4843D8, 32'hF49E50DC, 32'hF49E50DC, 32'hF49E50DC, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h11111111, 32'hF49E50DC, 32'h11111111, 32'h11111111, 1'b1, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 32'h22222222, 32'hF49E50DC, 32'h22222222, 32'h11111111, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 32'h22222222, 32'h33333333, 32'h33333333, 32'h11111111, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 32'h22222222, 32'h33333333, 32'h22222222, 32'h22222222, 1'b1, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 1'b1, 32'h01234567, 32'h89ABCDEF, 32'h89ABCDEF, 32'h89ABCDEF, 1'b1, 1'b1};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 32'h01234567, 32'h89ABCDEF, 32'h89ABCDEF, 32'h00000000, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 1'b1, 32'h01234567, 32'h89ABCDEF, 32'h89ABCDEF, 32'h00000000, 1'b0, 1'b0};
        vecs[19] = '{1'b1, 1'b1, 1'b1, 32'h01234567, 32'h89ABCDEF, 32'h89ABCDEF, 32'h00000000, 1'b0, 1'b0};
        vecs[20] = '{1'b1, 1'b0, 1'b1, 32'h01234567, 32'h89ABCDEF, 32'h89ABCDEF, 32'h89ABCDEF, 1'b1, 1'b1};

        rst_n           = 1'b0;
        bus.hold        = 1'b0;
        bus.select_line = 1'b1;
        bus.in_0        = 32'h0;
        bus.in_1        = 32'hFFFFFFFF;
        @(posedge clk);
        #1;

        for (int i = 0; i < 21; i++) begin
            rst_n           = vecs[i].rst_n;
            bus.hold        = vecs[i].hold;
            bus.select_line = vecs[i].sel;
            bus.in_0        = vecs[i].in_0;
            bus.in_1        = vecs[i].in_1;
            #1;
            chk($sformatf("v%0d out", i), bus.out, vecs[i].exp_out);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d out_q", i), bus.out_q, vecs[i].exp_q);
            chk($sformatf("v%0d out_valid", i), {31'b0, bus.out_valid}, {31'b0, vecs[i].exp_valid});
            chk($sformatf("v%0d sel_changed", i), {31'b0, bus.sel_changed}, {31'b0, vecs[i].exp_chg});
        end

        // Several input changes inside one cycle: only the final combination is captured.
        bus.in_0        = 32'h5A5A5A5A;
        bus.select_line = 1'b0;
        #2;
        chk("mid out a", bus.out, 32'h5A5A5A5A);
        bus.in_1        = 32'hC3C3C3C3;
        bus.select_line = 1'b1;
        #2;
        chk("mid out b", bus.out, 32'hC3C3C3C3);
        chk("mid out_q stable", bus.out_q, 32'h89ABCDEF);
        bus.in_1 = 32'h3C3C3C3C;
        #1;
        chk("mid out c", bus.out, 32'h3C3C3C3C);
        @(posedge clk);
        #1;
        chk("mid out_q", bus.out_q, 32'h3C3C3C3C);
        chk("mid sel_changed", {31'b0, bus.sel_changed}, 32'h0);

        // A single held cycle clears sel_changed even right after a change.
        bus.select_line = 1'b0;
        @(posedge clk);
        #1;
        chk("pre-hold sel_changed", {31'b0, bus.sel_changed}, 32'h1);
        chk("pre-hold out_q", bus.out_q, 32'h5A5A5A5A);
        bus.hold = 1'b1;
        @(posedge clk);
        #1;
        chk("hold clr sel_changed", {31'b0, bus.sel_changed}, 32'h0);
        chk("hold out_valid", {31'b0, bus.out_valid}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
